alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared types for the alu_pipe block.
//   alu_op_e    : 3-bit operation select (ADD..MUL)
//   alu_flags_t : packed {z, n, c, v} result flags
//   alu_state_e : control state (idle / sequential multiply in progress)
//   FlagsReset  : flag value while no result has been produced (z set)
package alu_pkg;

   typedef enum logic [2:0] {
      OpAdd = 3'd0,
      OpSub = 3'd1,
      OpAnd = 3'd2,
      OpOr  = 3'd3,
      OpXor = 3'd4,
      OpSll = 3'd5,
      OpSra = 3'd6,
      OpMul = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      StIdle,
      StMul
   } alu_state_e;

   localparam alu_flags_t FlagsReset = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential shift-add multiplier, low N bits of a*b.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (aborts a multiply)
//   start        : load a/b and process bit 0 on this edge
//   a, b         : operands, sampled only when start is high
//   done         : high for one cycle while product is valid (combinational)
//   product      : low N bits of a*b, valid while done is high
// The last partial-product addition is left combinational so that done rises
// N-1 cycles after start and the caller can register the result on that edge.
module alu_mul_seq #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] product
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] LastCnt = CW'(N - 1);

   logic [N-1:0]  acc_q;
   logic [N-1:0]  mcand_q;
   logic [N-1:0]  mplier_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic [N-1:0]  partial;

   assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done    = busy_q && (cnt_q == LastCnt);
   assign product = partial;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         // Bit 0 is folded into the load so the whole multiply spans N cycles.
         acc_q    <= b[0] ? a : '0;
         mcand_q  <= a << 1;
         mplier_q <= b >> 1;
         cnt_q    <= CW'(1);
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (done) begin
            busy_q <= 1'b0;
         end else begin
            acc_q    <= partial;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- registered ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (in1, in2, alu_op taken on accept)
//   in1, in2              : N-bit signed operands
//   alu_op                : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 MUL
//   out_valid / out_ready : result handshake; result held stable while stalled
//   alu_out, z, n, c, v   : result and zero/negative/carry/overflow flags
//   op_err                : result came from an unsupported op
// Build option ALU_PIPE_MUL_EN: op 7 runs the N-cycle sequential multiplier.
// Without it op 7 completes in one cycle with a zero result and op_err set.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [2:0]   alu_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] alu_out,
   output logic         z,
   output logic         n,
   output logic         c,
   output logic         v,
   output logic         op_err
);

   localparam int unsigned SW = $clog2(N);

`ifdef ALU_PIPE_MUL_EN
   localparam logic ErrOnMul = 1'b0;
`else
   localparam logic ErrOnMul = 1'b1;
`endif

   alu_op_e      op;
   alu_state_e   state_q, state_d;
   logic [N-1:0] out_q, out_d;
   alu_flags_t   flags_q, flags_d;
   logic         err_q, err_d;
   logic         valid_q, valid_d;

   logic         accept, single_go, mul_go, mul_done;
   logic [N-1:0] mul_product;
   logic [N-1:0] alu_res;
   logic [N:0]   sum_ext;
   logic         alu_c, alu_v, alu_err;
   logic [SW-1:0] shamt;

   assign op       = alu_op_e'(alu_op);
   assign in_ready = (state_q == StIdle) && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = in2[SW-1:0];

`ifdef ALU_PIPE_MUL_EN
   assign mul_go    = accept && (op == OpMul);
   assign single_go = accept && (op != OpMul);

   alu_mul_seq #(
      .N(N)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_go),
      .a      (in1),
      .b      (in2),
      .done   (mul_done),
      .product(mul_product)
   );
`else
   assign mul_go      = 1'b0;
   assign single_go   = accept;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // Single-cycle datapath; SUB carry is the carry out of in1 + ~in2 + 1.
   always_comb begin
      sum_ext = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      unique case (op)
         OpAdd: begin
            sum_ext = {1'b0, in1} + {1'b0, in2};
            alu_res = sum_ext[N-1:0];
            alu_c   = sum_ext[N];
            alu_v   = (in1[N-1] == in2[N-1]) && (alu_res[N-1] != in1[N-1]);
         end
         OpSub: begin
            sum_ext = {1'b0, in1} + {1'b0, ~in2} + {{N{1'b0}}, 1'b1};
            alu_res = sum_ext[N-1:0];
            alu_c   = sum_ext[N];
            alu_v   = (in1[N-1] != in2[N-1]) && (alu_res[N-1] != in1[N-1]);
         end
         OpAnd: alu_res = in1 & in2;
         OpOr:  alu_res = in1 | in2;
         OpXor: alu_res = in1 ^ in2;
         OpSll: alu_res = in1 << shamt;
         OpSra: alu_res = $unsigned($signed(in1) >>> shamt);
         OpMul: alu_err = ErrOnMul;
      endcase
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      flags_d = flags_q;
      err_d   = err_q;
      // A held result is dropped once taken unless replaced below.
      valid_d = valid_q && !out_ready;
      if (mul_done) begin
         state_d = StIdle;
         out_d   = mul_product;
         flags_d = '{z: (mul_product == '0), n: mul_product[N-1], c: 1'b0, v: 1'b0};
         err_d   = 1'b0;
         valid_d = 1'b1;
      end else if (single_go) begin
         out_d   = alu_res;
         flags_d = '{z: (alu_res == '0), n: alu_res[N-1], c: alu_c, v: alu_v};
         err_d   = alu_err;
         valid_d = 1'b1;
      end else if (mul_go) begin
         state_d = StMul;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         out_q   <= '0;
         flags_q <= FlagsReset;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         flags_q <= flags_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign alu_out   = out_q;
   assign z         = flags_q.z;
   assign n         = flags_q.n;
   assign c         = flags_q.c;
   assign v         = flags_q.v;
   assign op_err    = err_q;

endmodule
